// File: rtl/cnn_pkg.sv
// Shared types for the CNN layer sequencer: layer descriptor layout, FSM
// state encoding and the descriptor sanity check used before a layer starts.
package cnn_pkg;

    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 16;

    typedef enum logic {
        LAYER_CONV = 1'b0,
        LAYER_POOL = 1'b1
    } layer_type_e;

    typedef struct packed {
        layer_type_e        layerType;
        logic [DATA_SZ-1:0] imgsNumber;
        logic [DATA_SZ-1:0] imgSize;
        logic [DATA_SZ-1:0] windowSize;
        logic [ADDR_SZ-1:0] imgsAddress;
    } layer_desc_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LRST   = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4,
        S_ERR    = 3'd5
    } seq_state_e;

    // A pool window must be non-empty and fit inside the image.
    function automatic logic desc_is_bad(input layer_desc_t desc);
        logic bad;
        bad = 1'b0;
        if (desc.layerType == LAYER_POOL) begin
            bad = (desc.windowSize == {DATA_SZ{1'b0}}) ||
                  (desc.windowSize > desc.imgSize);
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Host/config and engine-control signals of the layer sequencer, bundled so the
// sequencer, the engines' glue and the bench share one definition.
interface cnn_layer_sequencer_if
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8
) ();

    localparam int LIDX_SZ = $clog2(MAX_LAYERS);

    logic                 cfgWrite;
    logic [LIDX_SZ-1:0]   cfgIdx;
    logic                 cfgType;
    logic [DATA_SZ-1:0]   cfgImgsNumber;
    logic [DATA_SZ-1:0]   cfgImgSize;
    logic [DATA_SZ-1:0]   cfgWindowSize;
    logic [ADDR_SZ-1:0]   cfgImgsAddress;
    logic [LIDX_SZ:0]     numLayers;
    logic                 start;

    logic                 convDone;
    logic                 poolDone;
    logic                 convReset;
    logic                 convEnable;
    logic                 poolReset;
    logic                 poolEnable;

    logic [DATA_SZ-1:0]   imgsNumber;
    logic [DATA_SZ-1:0]   imgSize;
    logic [DATA_SZ-1:0]   windowSize;
    logic [ADDR_SZ-1:0]   imgsAddress;
    logic [LIDX_SZ-1:0]   curLayer;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport seq (
        input  cfgWrite, cfgIdx, cfgType, cfgImgsNumber, cfgImgSize,
               cfgWindowSize, cfgImgsAddress, numLayers, start,
               convDone, poolDone,
        output convReset, convEnable, poolReset, poolEnable,
               imgsNumber, imgSize, windowSize, imgsAddress,
               curLayer, busy, done, error
    );

    modport host (
        output cfgWrite, cfgIdx, cfgType, cfgImgsNumber, cfgImgSize,
               cfgWindowSize, cfgImgsAddress, numLayers, start,
               convDone, poolDone,
        input  convReset, convEnable, poolReset, poolEnable,
               imgsNumber, imgSize, windowSize, imgsAddress,
               curLayer, busy, done, error
    );

endinterface

// File: rtl/cnn_layer_sequencer_desc_table.sv
// Layer descriptor register file: one synchronous write port for the host and
// one combinational read port for the sequencer's FETCH state.
module layer_desc_table
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    localparam int LIDX_SZ = $clog2(MAX_LAYERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LIDX_SZ-1:0] wr_idx,
    input  layer_desc_t        wr_desc,
    input  logic [LIDX_SZ-1:0] rd_idx,
    output layer_desc_t        rd_desc
);

    layer_desc_t mem_q [MAX_LAYERS];
    layer_desc_t mem_d [MAX_LAYERS];

    // Next table contents: current entries with the addressed slot replaced on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_desc;
        end else begin
            mem_d[wr_idx] = mem_q[wr_idx];
        end
    end

    // Table storage, cleared to all-zero descriptors on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_desc = mem_q[rd_idx];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks the programmed layer list, loading each descriptor onto the shared
// engine configuration bus and handshaking reset/enable/done with the engine.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8
) (
    input  logic                clk,
    input  logic                reset,
    cnn_layer_sequencer_if.seq  bus
);

    localparam int LIDX_SZ = $clog2(MAX_LAYERS);
    localparam logic [LIDX_SZ:0] LAYER_CNT_MAX = (LIDX_SZ+1)'(MAX_LAYERS);
    localparam logic [LIDX_SZ:0] IDX_ONE       = {{LIDX_SZ{1'b0}}, 1'b1};
    localparam logic [LIDX_SZ:0] IDX_ZERO      = {(LIDX_SZ+1){1'b0}};

    seq_state_e         state_q, state_d;
    logic [LIDX_SZ:0]   idx_q, idx_d;
    logic [LIDX_SZ:0]   num_layers_q, num_layers_d;
    layer_desc_t        cfg_q, cfg_d;
    logic [LIDX_SZ-1:0] cur_layer_q, cur_layer_d;
    logic               conv_reset_q, conv_reset_d;
    logic               conv_enable_q, conv_enable_d;
    logic               pool_reset_q, pool_reset_d;
    logic               pool_enable_q, pool_enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               wr_en_s;
    layer_desc_t        wr_desc_s;
    layer_desc_t        rd_desc_s;
    logic               count_ok_s;
    logic               sel_done_s;
    logic [LIDX_SZ:0]   idx_next_s;

    layer_desc_table #(
        .MAX_LAYERS (MAX_LAYERS)
    ) u_desc_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_idx  (bus.cfgIdx),
        .wr_desc (wr_desc_s),
        .rd_idx  (idx_q[LIDX_SZ-1:0]),
        .rd_desc (rd_desc_s)
    );

    // Host-side helpers: descriptor assembly, write gating and run-request checks.
    always_comb begin
        wr_desc_s.layerType   = layer_type_e'(bus.cfgType);
        wr_desc_s.imgsNumber  = bus.cfgImgsNumber;
        wr_desc_s.imgSize     = bus.cfgImgSize;
        wr_desc_s.windowSize  = bus.cfgWindowSize;
        wr_desc_s.imgsAddress = bus.cfgImgsAddress;
        wr_en_s    = bus.cfgWrite && ((state_q == S_IDLE) || (state_q == S_FINISH));
        count_ok_s = (bus.numLayers != IDX_ZERO) && (bus.numLayers <= LAYER_CNT_MAX);
        sel_done_s = (cfg_q.layerType == LAYER_POOL) ? bus.poolDone : bus.convDone;
        idx_next_s = idx_q + IDX_ONE;
    end

    // Next-state and registered-output logic; engine controls default low.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        num_layers_d  = num_layers_q;
        cfg_d         = cfg_q;
        cur_layer_d   = cur_layer_q;
        conv_reset_d  = 1'b0;
        conv_enable_d = 1'b0;
        pool_reset_d  = 1'b0;
        pool_enable_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = done_q;
        error_d       = error_q;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (bus.start) begin
                    done_d = 1'b0;
                    if (count_ok_s) begin
                        state_d      = S_FETCH;
                        idx_d        = IDX_ZERO;
                        num_layers_d = bus.numLayers;
                        busy_d       = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                cfg_d       = rd_desc_s;
                cur_layer_d = idx_q[LIDX_SZ-1:0];
                if (desc_is_bad(rd_desc_s)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    state_d      = S_LRST;
                    busy_d       = 1'b1;
                    conv_reset_d = (rd_desc_s.layerType == LAYER_CONV);
                    pool_reset_d = (rd_desc_s.layerType == LAYER_POOL);
                end
            end
            S_LRST: begin
                state_d       = S_RUN;
                busy_d        = 1'b1;
                conv_enable_d = (cfg_q.layerType == LAYER_CONV);
                pool_enable_d = (cfg_q.layerType == LAYER_POOL);
            end
            S_RUN: begin
                // The engine's done was cleared in LRST, so any done seen here is fresh.
                if (sel_done_s) begin
                    idx_d = idx_next_s;
                    if (idx_next_s == num_layers_q) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        busy_d  = 1'b1;
                    end
                end else begin
                    busy_d        = 1'b1;
                    conv_enable_d = (cfg_q.layerType == LAYER_CONV);
                    pool_enable_d = (cfg_q.layerType == LAYER_POOL);
                end
            end
            S_ERR: begin
                state_d = S_ERR;
                error_d = 1'b1;
            end
            default: begin
                state_d = S_ERR;
                error_d = 1'b1;
            end
        endcase
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= IDX_ZERO;
            num_layers_q  <= IDX_ZERO;
            cfg_q         <= '0;
            cur_layer_q   <= {LIDX_SZ{1'b0}};
            conv_reset_q  <= 1'b0;
            conv_enable_q <= 1'b0;
            pool_reset_q  <= 1'b0;
            pool_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            num_layers_q  <= num_layers_d;
            cfg_q         <= cfg_d;
            cur_layer_q   <= cur_layer_d;
            conv_reset_q  <= conv_reset_d;
            conv_enable_q <= conv_enable_d;
            pool_reset_q  <= pool_reset_d;
            pool_enable_q <= pool_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.convReset   = conv_reset_q;
    assign bus.convEnable  = conv_enable_q;
    assign bus.poolReset   = pool_reset_q;
    assign bus.poolEnable  = pool_enable_q;
    assign bus.imgsNumber  = cfg_q.imgsNumber;
    assign bus.imgSize     = cfg_q.imgSize;
    assign bus.windowSize  = cfg_q.windowSize;
    assign bus.imgsAddress = cfg_q.imgsAddress;
    assign bus.curLayer    = cur_layer_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Sequences a programmed list of CNN layer descriptors over the shared conv and pool layer engines. For each layer it presents the layer configuration, pulses that engine's reset, holds its enable until the engine reports done, and then advances to the next layer. It sits between the top-level host/config interface and the `conv_layer` / `pool_layer` instances, and is the only driver of their `reset`, `enable` and configuration inputs.

## Interface
- `MAX_LAYERS`, 8: descriptor table depth; `LIDX_SZ = $clog2(MAX_LAYERS)`.
- `DATA_SZ`, 16: width of count and size fields.
- `ADDR_SZ`, 16: memory address width.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cfgWrite` in 1: write descriptor `cfgIdx` this cycle.
- `cfgIdx` in LIDX_SZ: descriptor slot to write.
- `cfgType` in 1: 0 = conv, 1 = pool.
- `cfgImgsNumber`, `cfgImgSize`, `cfgWindowSize` in DATA_SZ each: descriptor fields.
- `cfgImgsAddress` in ADDR_SZ: descriptor input base address.
- `numLayers` in LIDX_SZ+1: layer count, sampled on an accepted `start`.
- `start` in 1: single-cycle run request.
- `convDone`, `poolDone` in 1: engine done levels.
- `convReset`, `convEnable`, `poolReset`, `poolEnable` out 1: engine controls.
- `imgsNumber`, `imgSize`, `windowSize` out DATA_SZ: shared configuration bus to both engines.
- `imgsAddress` out ADDR_SZ: shared configuration bus to both engines.
- `curLayer` out LIDX_SZ: index of the layer being run.
- `busy`, `done`, `error` out 1: status.

## Operation
- States: IDLE, FETCH, LRST, RUN, FINISH, ERR.
- **IDLE**
  - `cfgWrite` stores the descriptor.
  - `start` with `numLayers` in 1..MAX_LAYERS goes to FETCH and sets `idx=0`.
  - `start` with any other `numLayers` goes to ERR.
- **FETCH**
  - Registers descriptor[`idx`] onto the configuration bus and sets `curLayer=idx`.
  - A pool descriptor with `windowSize==0` or `windowSize>imgSize` goes to ERR.
  - Otherwise goes to LRST.
- **LRST**
  - Asserts the selected engine's reset for exactly 1 cycle; both enables stay low.
  - Goes to RUN.
- **RUN**
  - Holds the selected enable high.
  - Waits for the selected done; the unselected done is ignored.
  - On done: drops the enable the next cycle and increments `idx`.
  - If `idx` reaches the latched `numLayers`, goes to FINISH; otherwise goes to FETCH.
- **FINISH**
  - `done=1` and `busy=0`; both are held.
  - `start` re-runs the table, clearing `done`.
  - `cfgWrite` is allowed.
- **ERR**
  - `error=1` is held until `reset`; `start` is ignored.
- `busy=1` in FETCH, LRST and RUN.
- `cfgWrite` and `start` are ignored while busy.
- The configuration bus is stable from FETCH through the end of RUN; the engines sample it while enabled.
- Unselected engine controls: reset low, enable low.

## Timing
- All outputs are reset to 0: enables, engine resets, status, `curLayer` and the configuration bus.
- `reset` also clears all descriptors to 0 and returns the FSM to IDLE.
- `reset` mid-run: the engines are not separately reset by the sequencer; the top level also drives their resets from `reset`.
- Start latency: `start` at cycle t gives FETCH at t+1, the engine reset high at t+2, and the enable high at t+3.
- Layer handoff: done sampled at t gives the enable low at t+1 (FETCH), the next reset at t+2, and the next enable at t+3.
- Run end: done for the last layer sampled at t gives `done=1` at t+1.
- The engine's done clears during the LRST cycle. A stale done therefore cannot advance RUN; the bench asserts this.
- `cfgWrite` and `start` in the same IDLE cycle: the write is applied and the run uses the new descriptor (write-first).
- `numLayers` equal to MAX_LAYERS is legal; `idx` has width LIDX_SZ+1, so it does not wrap.

## Structure
- Shared package `cnn_pkg`:
  - `layer_type_e` {LAYER_CONV, LAYER_POOL}.
  - `layer_desc_t` struct (type, imgsNumber, imgSize, windowSize, imgsAddress).
  - `DATA_SZ` and `ADDR_SZ`.
- Sub-module `layer_desc_table`: MAX_LAYERS×`layer_desc_t` register file with a synchronous write port and a combinational read port.
- The FSM and output registers stay in `cnn_layer_sequencer`.

## Test plan
- **Two-layer run:** program conv {2,28,5,0x0000} and pool {6,24,2,0x1000}, `numLayers=2`, `start`; done responders have latencies 10 and 7.
  - `convReset` pulses at t+2 and `convEnable` is high t+3..t+13.
  - `poolReset` pulses 2 cycles after convDone.
  - `done=1` follows poolDone by 1 cycle, with `curLayer` reading 0 then 1.
- **Stale done:** `poolDone` held high before `start` on a single pool layer.
  - The enable stays high until the responder re-asserts done after LRST.
- **Bad pool descriptor:** pool descriptor with `windowSize=0` → `error=1` 2 cycles after `start`; no enable is ever asserted; `start` is then ignored.
- **Bad layer count:** `numLayers=0` or `9`, then `start` → ERR next cycle, `busy` never set.
- **Writes while busy:** `cfgWrite` to slot 0 during RUN is ignored; re-`start` from FINISH replays the original descriptor values.
- **Mid-run reset:** `reset` asserted during RUN of layer 1 → all outputs 0 the next cycle, the table reads zero, and the FSM is in IDLE.
